div_unit: RTL
=============

// Module: div_unit
// PURPOSE
//   Iterative multi-cycle divider for RV32M DIV/DIVU/REM/REMU. Sits beside the
//   combinational ALU in the execute stage. It does the inverse arithmetic the
//   ALU cannot do in one cycle: it takes operands on a start pulse and returns
//   the quotient or remainder via a busy/done handshake.
// PARAMETERS
//   WIDTH  32  operand/result width; iteration count = WIDTH
// PORTS
//   i_clk         in   1      clock, all state updates on rising edge
//   i_reset       in   1      synchronous, active-high reset
//   i_start       in   1      request; sampled only in IDLE
//   i_operand_a   in   WIDTH  dividend
//   i_operand_b   in   WIDTH  divisor
//   i_div_op      in   2      00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled with i_start
//   o_busy        out  1      high in CALC and DONE; low in IDLE
//   o_done        out  1      one-cycle pulse, high only in DONE
//   o_div_data    out  WIDTH  result; valid when o_done=1, held until next accepted start
// BEHAVIOUR
//   Reset: state=IDLE; o_busy=0, o_done=0, o_div_data=0; iteration count=0.
//     Reset mid-operation aborts the operation immediately, with no result.
//   FSM IDLE -> CALC -> DONE -> IDLE; special cases go IDLE -> DONE.
//   IDLE: when i_start=1, register the operands and the op (edge E0).
//     Divisor==0 or signed overflow goes to DONE at E0. Otherwise go to CALC.
//   CALC: restoring shift-subtract, one quotient bit per edge, MSB first, on
//     unsigned magnitudes. WIDTH iterations on edges E1..E_WIDTH. The sign fix
//     is applied at E_WIDTH, which is also the transition to DONE.
//   DONE: o_done=1 for exactly one cycle, then IDLE unconditionally.
//   Latency: normal ops, o_done is high in the cycle after edge E_WIDTH
//     (WIDTH+1 edges including E0). Special cases: high in the cycle after E0.
//   Signed ops (DIV, REM) use |a| and |b|:
//     - quotient is negated when sign(a) != sign(b);
//     - remainder takes the sign of a.
//   Unsigned ops (DIVU, REMU): no sign processing; 0xFFFFFFFF is the largest value.
//   Divide by zero (b=0), all ops:
//     - quotient = all ones;
//     - remainder = a.
//   Signed overflow (DIV/REM, a=0x80000000, b=0xFFFFFFFF):
//     - quotient = 0x80000000;
//     - remainder = 0.
//   i_start in CALC or DONE is ignored; it is neither queued nor restarts the op.
//   Operand/op inputs may change after E0 without affecting the result.
//   Invariant: a == q*b + r, with |r| < |b| for b != 0.
// TESTING
//   1 DIVU a=100,b=7 -> o_div_data=14, o_done high in cycle after E32; REMU -> 2
//   2 DIV a=-7(0xFFFFFFF9),b=2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; REM a=7,b=-2 -> 1
//   3 DIV a=0x1234,b=0 -> 0xFFFFFFFF, o_done in cycle after E0; REMU -> 0x1234
//   4 DIV a=0x80000000,b=0xFFFFFFFF -> 0x80000000 after E0; REM -> 0
//   5 DIVU a=0xFFFFFFFF,b=1 -> 0xFFFFFFFF; DIVU a=5,b=0xFFFFFFFF -> 0; REMU -> 5
//   6 start op, pulse i_start again at E5 -> ignored, first result unchanged;
//     i_reset at E10 -> next cycle busy=0, done=0, data=0; next op 100/7 -> 14

Source files
------------

// File: rtl/div_unit.sv
// div_unit: iterative restoring divider for RV32M DIV/DIVU/REM/REMU
// with a start/busy/done handshake and one quotient bit per clock.
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_operand_a,
   input  logic [WIDTH-1:0] i_operand_b,
   input  logic [1:0]       i_div_op,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_div_data
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] rem_q, quo_q, div_q, rem_d, quo_d, q_res, r_res;
   logic [WIDTH-1:0] a_abs, b_abs, spec_res;
   logic [WIDTH:0]   sub;
   logic             neg_q, rneg_q, sel_rem_q, ge, sgn, div0, ovf;
   always_comb begin
      sgn      = ~i_div_op[0];
      a_abs    = (sgn & i_operand_a[WIDTH-1]) ? -i_operand_a : i_operand_a;
      b_abs    = (sgn & i_operand_b[WIDTH-1]) ? -i_operand_b : i_operand_b;
      div0     = i_operand_b == '0;
      ovf      = sgn & (i_operand_a == MIN_NEG) & (&i_operand_b);
      spec_res = div0 ? (i_div_op[1] ? i_operand_a : '1) : (i_div_op[1] ? '0 : MIN_NEG);
      // the dividend shifts out of quo_q's MSB while quotient bits enter at its LSB
      sub      = {rem_q, quo_q[WIDTH-1]};
      ge       = sub >= {1'b0, div_q};
      rem_d    = ge ? sub[WIDTH-1:0] - div_q : sub[WIDTH-1:0];
      quo_d    = {quo_q[WIDTH-2:0], ge};
      q_res    = neg_q ? -quo_d : quo_d;
      r_res    = rneg_q ? -rem_d : rem_d;
   end
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         rem_q      <= '0;
         quo_q      <= '0;
         div_q      <= '0;
         neg_q      <= 1'b0;
         rneg_q     <= 1'b0;
         sel_rem_q  <= 1'b0;
         o_busy     <= 1'b0;
         o_done     <= 1'b0;
         o_div_data <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               o_done <= 1'b0;
               if (i_start) begin
                  o_busy <= 1'b1;
                  if (div0 | ovf) begin
                     o_div_data <= spec_res;
                     o_done     <= 1'b1;
                     state_q    <= DONE;
                  end else begin
                     quo_q     <= a_abs;
                     div_q     <= b_abs;
                     rem_q     <= '0;
                     cnt_q     <= '0;
                     neg_q     <= sgn & (i_operand_a[WIDTH-1] ^ i_operand_b[WIDTH-1]);
                     rneg_q    <= sgn & i_operand_a[WIDTH-1];
                     sel_rem_q <= i_div_op[1];
                     state_q   <= CALC;
                  end
               end
            end
            CALC: begin
               rem_q <= rem_d;
               quo_q <= quo_d;
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == CW'(WIDTH-1)) begin
                  o_div_data <= sel_rem_q ? r_res : q_res;
                  o_done     <= 1'b1;
                  state_q    <= DONE;
               end
            end
            default: begin
               o_done  <= 1'b0;
               o_busy  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end
endmodule
